// File: rtl/vga_in_decoder.sv
// rtl/vga_in_decoder.sv - VGA link receiver: recovers coordinates from sync edges, checks geometry, locks.
// Two register stages from pins to outputs; the lock FSM runs off stage-1 edge detection.
module vga_in_decoder #(
    parameter int unsigned H_TOTAL     = 1680,
    parameter int unsigned H_ACT_START = 336,
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_TOTAL     = 828,
    parameter int unsigned V_ACT_START = 27,
    parameter int unsigned V_ACTIVE    = 800,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  pix_in_r,
    input  logic [3:0]  pix_in_g,
    input  logic [3:0]  pix_in_b,
    output logic        pix_valid,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_END     = 11'(H_TOTAL);
    localparam logic [10:0] H_A0      = 11'(H_ACT_START);
    localparam logic [10:0] H_A1      = 11'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_A0      = 10'(V_ACT_START);
    localparam logic [9:0]  V_A1      = 10'(V_ACT_START + V_ACTIVE - 1);
    localparam logic [3:0]  GOOD_NEED = 4'(LOCK_FRAMES);

    logic        s1_hs_q, s1_vs_q, s1_hs_prev_q;
    logic [3:0]  s1_r_q, s1_g_q, s1_b_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vs_at_ls_q, seen_line_q, seen_frame_q;
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        pix_valid_q, frame_start_q;
    logic [3:0]  pix_r_q, pix_g_q, pix_b_q;
    logic [10:0] curr_x_q;
    logic [9:0]  curr_y_q;

    logic line_start, frame_start_c, err, active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b0;
            s1_hs_prev_q <= 1'b1;
            s1_r_q       <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
        end else begin
            s1_hs_q      <= hsync;
            s1_vs_q      <= vsync;
            s1_hs_prev_q <= s1_hs_q;
            s1_r_q       <= pix_in_r;
            s1_g_q       <= pix_in_g;
            s1_b_q       <= pix_in_b;
        end
    end

    assign line_start    = s1_hs_prev_q & ~s1_hs_q;
    assign frame_start_c = line_start & s1_vs_q & ~vs_at_ls_q;

    // hcnt_d/vcnt_d are the coordinates of the pixel currently held in stage 1.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (line_start)
            hcnt_d = '0;
        else if (hcnt_q != 11'h7ff)
            hcnt_d = hcnt_q + 11'd1;
        if (frame_start_c)
            vcnt_d = '0;
        else if (line_start && vcnt_q != 10'h3ff)
            vcnt_d = vcnt_q + 10'd1;
    end

    // A line that overran was already flagged at H_END, so its closing edge is only short-checked below H_LAST.
    assign err = (line_start && seen_line_q && hcnt_q < H_LAST)
              || (hcnt_q == H_END)
              || (frame_start_c && seen_frame_q && vcnt_q != V_LAST);

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (frame_start_c) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                if (err) begin
                    state_d = ST_UNLOCKED;
                end else if (frame_start_c) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == GOOD_NEED)
                        state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (err)
                    state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase
        if (err && state_q != ST_UNLOCKED && err_count_q != 8'hff)
            err_count_d = err_count_q + 8'd1;
    end

    assign locked = (state_q == ST_LOCKED);
    assign active = locked && hcnt_d >= H_A0 && hcnt_d <= H_A1 && vcnt_d >= V_A0 && vcnt_d <= V_A1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            vs_at_ls_q    <= 1'b0;
            seen_line_q   <= 1'b0;
            seen_frame_q  <= 1'b0;
            state_q       <= ST_UNLOCKED;
            good_q        <= '0;
            err_count_q   <= '0;
            pix_valid_q   <= 1'b0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            curr_x_q      <= 11'h400;
            curr_y_q      <= 10'h200;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            if (line_start) begin
                vs_at_ls_q  <= s1_vs_q;
                seen_line_q <= 1'b1;
            end
            if (frame_start_c)
                seen_frame_q <= 1'b1;
            state_q       <= state_d;
            good_q        <= good_d;
            err_count_q   <= err_count_d;
            frame_start_q <= frame_start_c;
            pix_valid_q   <= active;
            pix_r_q       <= active ? s1_r_q : 4'h0;
            pix_g_q       <= active ? s1_g_q : 4'h0;
            pix_b_q       <= active ? s1_b_q : 4'h0;
            curr_x_q      <= active ? hcnt_d - H_A0 : 11'h400;
            curr_y_q      <= active ? vcnt_d - V_A0 : 10'h200;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign curr_x      = curr_x_q;
    assign curr_y      = curr_y_q;
    assign frame_start = frame_start_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_in_decoder.sv
// tb/tb_vga_in_decoder.sv - directed bench for vga_in_decoder on a reduced 40x20 geometry.
module tb_vga_in_decoder;

    localparam int H_TOTAL = 40, H_ACT_START = 8, H_ACTIVE = 16;
    localparam int V_TOTAL = 20, V_ACT_START = 4, V_ACTIVE = 8;

    logic        clk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b0;
    logic [3:0]  pix_in_r = '0, pix_in_g = '0, pix_in_b = '0;
    logic        pix_valid, frame_start, locked;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic [7:0]  err_count;

    vga_in_decoder #(
        .H_TOTAL(H_TOTAL), .H_ACT_START(H_ACT_START), .H_ACTIVE(H_ACTIVE),
        .V_TOTAL(V_TOTAL), .V_ACT_START(V_ACT_START), .V_ACTIVE(V_ACTIVE),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .pix_in_r(pix_in_r), .pix_in_g(pix_in_g), .pix_in_b(pix_in_b),
        .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .curr_x(curr_x), .curr_y(curr_y), .frame_start(frame_start),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          chk;
        logic [35:0] exp;
    } rec_t;

    rec_t sb_q[$];
    int   cyc = 0;
    int   compared = 0, mismatched = 0;
    int   hc = 0, vc = 0, nvalid = 0;
    bit   exp_lk = 0, chk_en = 0;

    logic [35:0] obs;
    assign obs = {pix_valid, curr_x, curr_y, pix_r, pix_g, pix_b, frame_start, locked};

    localparam logic [35:0] RST_OUT = {1'b0, 11'h400, 10'h200, 12'h000, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [35:0] o, input logic [35:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        rec_t r;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            r = sb_q.pop_front();
            if (r.chk && r.due == cyc)
                check("stream", obs, r.exp);
        end
        if (pix_valid) nvalid++;
    end

    // One source clock at (hc, vc): hsync low for 4 clocks, vsync high on line 0.
    task automatic px();
        logic [3:0]  r, g, b;
        logic        act;
        logic [35:0] e;
        r = 4'($urandom());
        g = 4'($urandom());
        b = 4'($urandom());
        hsync = !(hc < 4);
        vsync = (vc == 0);
        pix_in_r = r; pix_in_g = g; pix_in_b = b;
        act = exp_lk && hc >= H_ACT_START && hc < H_ACT_START + H_ACTIVE
                     && vc >= V_ACT_START && vc < V_ACT_START + V_ACTIVE;
        e = {act, act ? 11'(hc - H_ACT_START) : 11'h400, act ? 10'(vc - V_ACT_START) : 10'h200,
             act ? {r, g, b} : 12'h000, (hc == 0 && vc == 0), exp_lk};
        sb_q.push_back('{due: cyc + 2, chk: chk_en, exp: e});
        if (hc == 2500) check("hcnt_sat", 36'(dut.hcnt_q), 36'd2047);
        @(posedge clk);
        #1;
        hc++;
    endtask

    task automatic reset_mid();
        sb_q.delete();
        chk_en = 0;
        rst = 1'b1;
        #1;
        check("async_rst_out", obs, RST_OUT);
        check("async_rst_err", 36'(err_count), 36'd0);
        exp_lk = 0;
        repeat (5) px();
        rst = 1'b0;
        chk_en = 1;
    endtask

    task automatic line(input int len, input int sw_hc, input bit sw_lk, input bit do_rst);
        hc = 0;
        while (hc < len) begin
            if (hc == sw_hc) exp_lk = sw_lk;
            if (do_rst && vc == 7 && hc == 15) reset_mid();
            px();
        end
        vc++;
    endtask

    task automatic frame(input int nlines, input int len, input int sp_line, input int sp_len,
                         input int sw_line, input int sw_hc, input bit sw_lk, input bit do_rst);
        vc = 0;
        nvalid = 0;
        for (int l = 0; l < nlines; l++)
            line((l == sp_line) ? sp_len : len, (l == sw_line) ? sw_hc : -1, sw_lk, do_rst);
    endtask

    task automatic clean_frame();
        frame(V_TOTAL, H_TOTAL, -1, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic lock_frame();
        frame(V_TOTAL, H_TOTAL, -1, 0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", obs, RST_OUT);
        check("reset_err", 36'(err_count), 36'd0);
        rst = 1'b0;
        chk_en = 1;

        // clean loopback: lock on the third frame start
        clean_frame();
        clean_frame();
        lock_frame();
        check("lock_frame_valid", 36'(nvalid), 36'd128);
        clean_frame();
        check("clean_valid", 36'(nvalid), 36'd128);
        check("clean_err", 36'(err_count), 36'd0);

        // short line 5 while locked; unlock at line 6 start, relock on the third frame start
        frame(V_TOTAL, H_TOTAL, 5, H_TOTAL - 1, 6, 0, 1'b0, 1'b0);
        check("short_err", 36'(err_count), 36'd1);
        check("short_valid", 36'(nvalid), 36'd32);
        clean_frame();
        clean_frame();
        lock_frame();
        check("short_relock_err", 36'(err_count), 36'd1);

        // missing hsync: line 5 runs 3000 clocks, unlock when the count passes H_TOTAL
        frame(V_TOTAL, H_TOTAL, 5, 3000, 5, H_TOTAL + 1, 1'b0, 1'b0);
        check("miss_err", 36'(err_count), 36'd2);
        check("miss_valid", 36'(nvalid), 36'd32);

        // 21-line frame while in CHECK
        clean_frame();
        frame(V_TOTAL + 1, H_TOTAL, -1, 0, -1, 0, 1'b0, 1'b0);
        clean_frame();
        check("flen_err", 36'(err_count), 36'd3);
        check("flen_valid", 36'(nvalid), 36'd0);
        clean_frame();
        clean_frame();
        lock_frame();
        check("flen_relock_valid", 36'(nvalid), 36'd128);

        // reset mid-active at (15,7), then relock on the third frame start
        frame(V_TOTAL, H_TOTAL, -1, 0, -1, 0, 1'b0, 1'b1);
        clean_frame();
        clean_frame();
        lock_frame();
        check("rst_relock_valid", 36'(nvalid), 36'd128);
        check("rst_relock_err", 36'(err_count), 36'd0);

        // saturation: 2-line frames of 6 clocks give one counted error each
        chk_en = 0;
        for (int k = 0; k < 100; k++) frame(2, 6, -1, 0, -1, 0, 1'b0, 1'b0);
        check("sat_err_100", 36'(err_count), 36'd100);
        for (int k = 0; k < 200; k++) frame(2, 6, -1, 0, -1, 0, 1'b0, 1'b0);
        check("sat_err_255", 36'(err_count), 36'd255);
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
